// File: rtl/mem_interface_q.sv
// mem_interface_q: cache-line simulation memory behind the L2/fill path.
// Separate in-order read and write transaction queues with fixed latencies.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   mem_raddr/_trans/_req/_ack    read request channel (line address, id)
//   mem_rdata/_trans/_req/_ack    read return channel with backpressure
//   mem_waddr/_trans/_req/_ack    write request channel (line address, id)
//   mem_wdata, mem_wmask          write line data and byte enables
//   mem_wdata_trans/_done         one-cycle in-order write completion pulse

module mem_interface_q #(
    parameter int NPHYS            = 56,
    parameter int CACHE_LINE_SIZE  = 512,
    parameter int ACACHE_LINE_SIZE = $clog2(CACHE_LINE_SIZE / 8),
    parameter int MEM_SIZE         = 8 * 1024 * 1024,
    parameter int RTSIZE           = 8,
    parameter int WTSIZE           = 5,
    parameter int NRTRANS          = 4,
    parameter int NWTRANS          = 4,
    parameter int RLAT             = 40,
    parameter int WLAT             = 40
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NPHYS-ACACHE_LINE_SIZE-1:0]   mem_raddr,
    input  logic [RTSIZE-1:0]                   mem_raddr_trans,
    input  logic                                mem_raddr_req,
    output logic                                mem_raddr_ack,
    output logic [CACHE_LINE_SIZE-1:0]          mem_rdata,
    output logic [RTSIZE-1:0]                   mem_rdata_trans,
    output logic                                mem_rdata_req,
    input  logic                                mem_rdata_ack,
    input  logic [NPHYS-ACACHE_LINE_SIZE-1:0]   mem_waddr,
    input  logic [WTSIZE-1:0]                   mem_waddr_trans,
    input  logic                                mem_waddr_req,
    output logic                                mem_waddr_ack,
    input  logic [CACHE_LINE_SIZE-1:0]          mem_wdata,
    input  logic [CACHE_LINE_SIZE/8-1:0]        mem_wmask,
    output logic [WTSIZE-1:0]                   mem_wdata_trans,
    output logic                                mem_wdata_done
);

    localparam int AW  = NPHYS - ACACHE_LINE_SIZE;
    localparam int NB  = CACHE_LINE_SIZE / 8;
    localparam int IW  = $clog2(MEM_SIZE);
    localparam int RQW = $clog2(NRTRANS);
    localparam int RPW = RQW + 1;
    localparam int WQW = $clog2(NWTRANS);
    localparam int WPW = WQW + 1;
    localparam int RCW = $clog2(RLAT + 1);
    localparam int WCW = $clog2(WLAT + 1);

    localparam logic [RPW-1:0] RDEPTH = RPW'(NRTRANS);
    localparam logic [WPW-1:0] WDEPTH = WPW'(NWTRANS);
    localparam logic [RCW-1:0] RLOAD  = RCW'(RLAT - 1);
    localparam logic [WCW-1:0] WLOAD  = WCW'(WLAT - 1);

    // Backing store; not cleared by reset.
    logic [CACHE_LINE_SIZE-1:0] r_mem [MEM_SIZE];

    // Read queue
    logic [IW-1:0]     r_ridx_q   [NRTRANS];
    logic [RTSIZE-1:0] r_rtrans_q [NRTRANS];
    logic [RCW-1:0]    r_rcnt     [NRTRANS];
    logic [RPW-1:0]    r_rhead;
    logic [RPW-1:0]    r_rtail;

    // Write queue (data is merged at accept, so only ids are kept)
    logic [WTSIZE-1:0] r_wtrans_q [NWTRANS];
    logic [WCW-1:0]    r_wcnt     [NWTRANS];
    logic [WPW-1:0]    r_whead;
    logic [WPW-1:0]    r_wtail;

    // Registered outputs
    logic                       r_raddr_ack;
    logic                       r_rdata_req;
    logic [CACHE_LINE_SIZE-1:0] r_rdata;
    logic [RTSIZE-1:0]          r_rdata_trans;
    logic                       r_waddr_ack;
    logic                       r_wdata_done;
    logic [WTSIZE-1:0]          r_wdata_trans;

    // Read-side wires
    logic           w_racc;
    logic           w_rpop;
    logic [RPW-1:0] w_rused;
    logic [RPW-1:0] w_rleft;
    logic [RPW-1:0] w_rused_nxt;
    logic [RPW-1:0] w_rcand_ptr;
    logic [RQW-1:0] w_rcand;
    logic [RQW-1:0] w_rtail_idx;
    logic           w_rpresent;
    logic [IW-1:0]  w_ridx;

    // Write-side wires
    logic           w_wacc;
    logic           w_wpop;
    logic [WPW-1:0] w_wused;
    logic [WPW-1:0] w_wused_nxt;
    logic [WQW-1:0] w_whead_idx;
    logic [WQW-1:0] w_wtail_idx;
    logic [IW-1:0]  w_widx;

    // Upper line-address bits alias onto the array and are ignored.
    generate
        if (AW > IW) begin : g_alias
            logic w_unused_hi;
            assign w_unused_hi = ^{mem_raddr[AW-1:IW], mem_waddr[AW-1:IW]};
        end
    endgenerate

    assign w_ridx = mem_raddr[IW-1:0];
    assign w_widx = mem_waddr[IW-1:0];

    // ---------------- read queue control ----------------
    assign w_racc      = mem_raddr_req & r_raddr_ack & ~reset;
    assign w_rpop      = r_rdata_req & mem_rdata_ack;
    assign w_rused     = r_rtail - r_rhead;
    assign w_rleft     = w_rused - RPW'(w_rpop);
    assign w_rused_nxt = w_rleft + RPW'(w_racc);
    assign w_rtail_idx = r_rtail[RQW-1:0];

    // The head stays in the queue while presented; on the ack edge the
    // candidate becomes the next entry so lines can stream back-to-back.
    assign w_rcand_ptr = w_rpop ? r_rhead + RPW'(1) : r_rhead;
    assign w_rcand     = w_rcand_ptr[RQW-1:0];
    assign w_rpresent  = (~r_rdata_req | mem_rdata_ack) &
                         (w_rleft != '0) &
                         (r_rcnt[w_rcand] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rhead       <= '0;
            r_rtail       <= '0;
            r_raddr_ack   <= 1'b0;
            r_rdata_req   <= 1'b0;
            r_rdata       <= '0;
            r_rdata_trans <= '0;
        end else begin
            r_raddr_ack <= (w_rused_nxt < RDEPTH);
            if (w_racc) begin
                r_rtail <= r_rtail + RPW'(1);
            end
            if (w_rpop) begin
                r_rhead <= r_rhead + RPW'(1);
            end
            // Memory is sampled at presentation so earlier-accepted reads
            // still observe writes merged while they waited.
            if (w_rpresent) begin
                r_rdata_req   <= 1'b1;
                r_rdata       <= r_mem[r_ridx_q[w_rcand]];
                r_rdata_trans <= r_rtrans_q[w_rcand];
            end else if (w_rpop) begin
                r_rdata_req <= 1'b0;
            end
        end
    end

    // Entry storage and countdowns. Reset only needs to clear the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRTRANS; i++) begin
            if (r_rcnt[i] != '0) begin
                r_rcnt[i] <= r_rcnt[i] - RCW'(1);
            end
        end
        if (w_racc) begin
            r_rcnt[w_rtail_idx]     <= RLOAD;
            r_ridx_q[w_rtail_idx]   <= w_ridx;
            r_rtrans_q[w_rtail_idx] <= mem_raddr_trans;
        end
    end

    // ---------------- write queue control ----------------
    assign w_wacc      = mem_waddr_req & r_waddr_ack & ~reset;
    assign w_wused     = r_wtail - r_whead;
    assign w_whead_idx = r_whead[WQW-1:0];
    assign w_wtail_idx = r_wtail[WQW-1:0];
    assign w_wpop      = (w_wused != '0) & (r_wcnt[w_whead_idx] == '0);
    assign w_wused_nxt = w_wused - WPW'(w_wpop) + WPW'(w_wacc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_whead       <= '0;
            r_wtail       <= '0;
            r_waddr_ack   <= 1'b0;
            r_wdata_done  <= 1'b0;
            r_wdata_trans <= '0;
        end else begin
            r_waddr_ack  <= (w_wused_nxt < WDEPTH);
            r_wdata_done <= w_wpop;
            if (w_wacc) begin
                r_wtail <= r_wtail + WPW'(1);
            end
            if (w_wpop) begin
                r_whead       <= r_whead + WPW'(1);
                r_wdata_trans <= r_wtrans_q[w_whead_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NWTRANS; i++) begin
            if (r_wcnt[i] != '0) begin
                r_wcnt[i] <= r_wcnt[i] - WCW'(1);
            end
        end
        if (w_wacc) begin
            r_wcnt[w_wtail_idx]     <= WLOAD;
            r_wtrans_q[w_wtail_idx] <= mem_waddr_trans;
        end
    end

    // Byte-masked merge at the accept edge.
    always_ff @(posedge clk) begin
        if (w_wacc) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wmask[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign mem_raddr_ack   = r_raddr_ack;
    assign mem_rdata       = r_rdata;
    assign mem_rdata_trans = r_rdata_trans;
    assign mem_rdata_req   = r_rdata_req;
    assign mem_waddr_ack   = r_waddr_ack;
    assign mem_wdata_trans = r_wdata_trans;
    assign mem_wdata_done  = r_wdata_done;

endmodule

// File: doc/mem_interface_q.md
Name: mem_interface_q

Overview:
- Parametrised successor to the cache-line simulation memory model that sits behind the L2/fill path in testbenches.
- Accepts cache-line read and write requests into separate transaction queues of configurable depth.
- Returns reads strictly in acceptance order after a programmable fixed latency, with rdata backpressure.
- Adds byte-masked writes and in-order write-completion reporting, each write reported exactly once.

Parameters:
NPHYS, 56, physical address width
CACHE_LINE_SIZE, 512, line width in bits
ACACHE_LINE_SIZE, $clog2(CACHE_LINE_SIZE/8), byte-offset bits dropped from addresses
MEM_SIZE, 8*1024*1024, number of lines in the backing array (power of 2)
RTSIZE, 8, read transaction id width
WTSIZE, 5, write transaction id width
NRTRANS, 4, read queue depth (power of 2, >=2)
NWTRANS, 4, write queue depth (power of 2, >=2)
RLAT, 40, read latency in cycles (>=1)
WLAT, 40, write completion latency in cycles (>=1)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
mem_raddr  in  NPHYS-ACACHE_LINE_SIZE  read line address
mem_raddr_trans  in  RTSIZE  read transaction id
mem_raddr_req  in  1  read request valid
mem_raddr_ack  out  1  read queue can accept
mem_rdata  out  CACHE_LINE_SIZE  returned line
mem_rdata_trans  out  RTSIZE  id of returned line
mem_rdata_req  out  1  returned line valid
mem_rdata_ack  in  1  consumer takes returned line
mem_waddr  in  NPHYS-ACACHE_LINE_SIZE  write line address
mem_waddr_trans  in  WTSIZE  write transaction id
mem_waddr_req  in  1  write request valid
mem_waddr_ack  out  1  write queue can accept
mem_wdata  in  CACHE_LINE_SIZE  write line data
mem_wmask  in  CACHE_LINE_SIZE/8  byte enables, 1 = write byte
mem_wdata_trans  out  WTSIZE  id of completed write
mem_wdata_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: raddr_ack=0, waddr_ack=0, rdata_req=0, wdata_done=0, trans/data outputs 0. All queue entries are dropped at reset; memory array contents are retained.
- Transfers occur at a posedge only with req && ack.
- mem_raddr_ack is registered. It is 1 when the read queue has at least one free entry after this edge's accept and retire are applied.
  - A full queue with a simultaneous retire keeps ack at 1.
- mem_waddr_ack follows the same rule for the write queue.
- Queues are circular FIFOs with head and tail pointers of width $clog2(depth)+1. Full/empty are decided by pointer compare, with wrap handled by the extra bit.
- Each accepted entry loads a countdown with RLAT-1 (reads) or WLAT-1 (writes). The counter decrements each cycle to 0 and then holds.
- Read return:
  - When the head entry count is 0 and no line is presented, the block registers mem_rdata from memory at the head address, loads rdata_trans, and sets rdata_req=1.
  - Request accepted at edge N: earliest rdata_req=1 after edge N+RLAT.
  - Presented data and id hold stable while rdata_req && !rdata_ack.
  - On the rdata_ack edge the head retires. If the next entry is ready, it is presented at that same edge with no bubble, giving 1 line/cycle throughput.
  - Entries behind a stalled head keep counting down.
- Write:
  - Data is merged into memory at the accept edge. Bytes with mask=1 are replaced; mask=0 bytes are kept.
  - The write is visible to any read presented at a later edge, including reads accepted earlier. Reads sample memory at presentation, not at acceptance.
  - Completion: when the write head count is 0, the block pulses wdata_done=1 for one cycle with wdata_trans = the head id, then retires the head. At most one completion per cycle, in acceptance order.
- Address index = addr[$clog2(MEM_SIZE)-1:0] of the line address; upper bits are ignored (aliasing).
- Same-cycle read accept and write accept to the same line: both are accepted; the read later returns the merged data.
- Reset asserted mid-operation: outputs go to their reset values at that edge. No stale rdata_req or wdata_done is issued after reset deasserts.

Test Plan:
- After reset, read addr 0x10 id 0x5A at edge N with rdata_ack=1 -> rdata_req first 1 after edge N+40, trans=0x5A, data = preloaded mem[0x10].
- 4 reads on consecutive cycles, none retired -> raddr_ack=0 after the 4th accept; with rdata_ack tied 1, 4 returns in order on 4 consecutive cycles; ack returns to 1.
- rdata_ack held 0 for 20 cycles after rdata_req -> data and trans stable; queued reads then return back-to-back on release.
- Write line 0x20 all 0xFF, mask=all 1, then write 0x00 with mask=0x...0001 -> later read returns byte0=0x00, all other bytes 0xFF.
- Writes with ids 3,4,5 on consecutive cycles, WLAT=40 -> wdata_done single-cycle pulses 40 cycles after each accept with trans 3,4,5; no duplicate or missing ids.
- Reset for 1 cycle while 2 reads and 2 writes are outstanding -> no rdata_req or wdata_done afterwards; both acks return to 1 one cycle after reset deasserts.
